// File: rtl/l2_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_arbiter_pkg
//  Description : Shared types and constants for the L2 memory-port arbiter.
//                This includes the arbiter state encoding, the pending-request
//                entry, and the default line geometry.
//                Related option: L2_MEM_ARB_DATA_PRIO_EN (used by l2_mem_arbiter).
//  Revision    : 1.0 - initial release
// ============================================================================
package l2_mem_arbiter_pkg;

    // Default number of beats in one cache-line transfer.
    localparam int L2_LINE_WORDS = 8;

    // Width of the line address that is held in a pending entry.
    localparam int L2_ADDR_W = 32;

    // Arbiter sequencing states. The encoding is explicit so that it stays
    // stable across tools.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BURST = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_t;

    // One captured request: a sticky valid bit and the line address that was
    // sampled on the request's rising edge.
    typedef struct packed {
        logic                 valid;
        logic [L2_ADDR_W-1:0] addr;
    } pend_entry_t;

endpackage : l2_mem_arbiter_pkg
`default_nettype wire

// File: rtl/l2_mem_req_capture.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_req_capture
//  Description : Rising-edge capture for a single L2 memory request.
//                A new edge sets a sticky pending bit and latches the address.
//                The pending bit is cleared when the arbiter signals done.
//                A level that is still held after done never re-triggers.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_req_capture
    import l2_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = L2_ADDR_W
) (
    input  logic              clk_l2,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_clr,
    output pend_entry_t       o_entry
);

    logic        r_req_prev;
    logic        w_rise;
    pend_entry_t r_entry;

    assign w_rise  = i_req & ~r_req_prev;
    assign o_entry = r_entry;

    // Remember the previous request level so that edges can be detected.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_req_prev <= 1'b0;
        end else begin
            r_req_prev <= i_req;
        end
    end

    // Set pending on a fresh edge; a same-cycle new edge outranks the clear.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (w_rise) begin
            r_entry.valid <= 1'b1;
            r_entry.addr  <= L2_ADDR_W'(i_addr);
        end else if (i_clr) begin
            r_entry.valid <= 1'b0;
        end
    end

endmodule : l2_mem_req_capture
`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : l2_mem_arbiter
//  Description : Shares the L2 line-transfer port to main memory between the
//                instruction and data L2 controller channels.
//                Within a channel, writeback is served before fill.
//                Between channels, arbitration is round-robin.
//                Each grant runs a LINE_WORDS-beat burst.
//                On completion, a one-cycle done pulse is sent to the channel.
//                Option L2_MEM_ARB_DATA_PRIO_EN: the data channel always wins
//                over the instruction channel, and no round-robin is used.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_mem_arbiter
    import l2_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = L2_ADDR_W,   // pending entries hold L2_ADDR_W bits
    parameter int LINE_WORDS = L2_LINE_WORDS
) (
    input  logic                          clk_l2,
    input  logic                          rst_n,
    input  logic                          inst_mem_dirty_req,
    input  logic                          inst_mem_replace_req,
    input  logic [ADDR_W-1:0]             inst_dirty_addr,
    input  logic [ADDR_W-1:0]             inst_replace_addr,
    output logic                          inst_mem_dirty_done,
    output logic                          inst_mem_replace_done,
    input  logic                          data_mem_dirty_req,
    input  logic                          data_mem_replace_req,
    input  logic [ADDR_W-1:0]             data_dirty_addr,
    input  logic [ADDR_W-1:0]             data_replace_addr,
    output logic                          data_mem_dirty_done,
    output logic                          data_mem_replace_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_beat_ack,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic                          owner_data
);

    localparam int                c_BEAT_W = $clog2(LINE_WORDS);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);

    // Request slot order: {channel, fill}. 0 inst dirty, 1 inst fill,
    // 2 data dirty, 3 data fill.
    logic [3:0]        w_req;
    logic [ADDR_W-1:0] w_req_addr [4];
    logic [3:0]        w_clr;
    pend_entry_t       w_pend [4];

    arb_state_t        r_state;
    arb_state_t        w_next_state;

    logic              r_owner_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [c_BEAT_W-1:0] r_beat;

    logic              w_inst_any;
    logic              w_data_any;
    logic              w_any;
    logic              w_pick_data;
    logic              w_pick_dirty;
    logic [1:0]        w_pick_idx;

    logic              w_mem_req;
    logic [3:0]        w_done;

    assign w_req = {data_mem_replace_req, data_mem_dirty_req,
                    inst_mem_replace_req, inst_mem_dirty_req};
    assign w_req_addr[0] = inst_dirty_addr;
    assign w_req_addr[1] = inst_replace_addr;
    assign w_req_addr[2] = data_dirty_addr;
    assign w_req_addr[3] = data_replace_addr;

    // Capture each request independently; the done pulse clears its own slot.
    for (genvar gi = 0; gi < 4; gi++) begin : g_capture
        l2_mem_req_capture #(
            .ADDR_W (ADDR_W)
        ) u_capture (
            .clk_l2  (clk_l2),
            .rst_n   (rst_n),
            .i_req   (w_req[gi]),
            .i_addr  (w_req_addr[gi]),
            .i_clr   (w_clr[gi]),
            .o_entry (w_pend[gi])
        );
    end

    assign w_inst_any = w_pend[0].valid | w_pend[1].valid;
    assign w_data_any = w_pend[2].valid | w_pend[3].valid;
    assign w_any      = w_inst_any | w_data_any;

`ifdef L2_MEM_ARB_DATA_PRIO_EN
    // Fixed priority: any pending data request beats the instruction channel.
    assign w_pick_data = w_data_any;
`else
    logic r_rr_data;   // 1: data channel has the turn when both are pending

    assign w_pick_data = w_data_any & (~w_inst_any | r_rr_data);

    // Hand the turn to the channel that was not served by the finished burst.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_data <= 1'b0;
        end else if (r_state == ARB_DONE) begin
            r_rr_data <= ~r_owner_data;
        end
    end
`endif

    // Within the chosen channel, writeback goes ahead of fill.
    assign w_pick_dirty = w_pick_data ? w_pend[2].valid : w_pend[0].valid;
    assign w_pick_idx   = {w_pick_data, ~w_pick_dirty};

    // State register.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant, a burst of LINE_WORDS accepted beats, then done.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE:  if (w_any) w_next_state = ARB_GRANT;
            ARB_GRANT: w_next_state = ARB_BURST;
            ARB_BURST: if (mem_beat_ack && (r_beat == c_LAST_BEAT)) w_next_state = ARB_DONE;
            ARB_DONE:  w_next_state = ARB_IDLE;
            default:   w_next_state = ARB_IDLE;
        endcase
    end

    // State outputs: the port request, plus the done pulse that also clears the
    // served pending slot.
    always_comb begin
        w_mem_req = 1'b0;
        w_done    = 4'b0000;
        case (r_state)
            ARB_GRANT: w_mem_req = 1'b1;
            ARB_BURST: w_mem_req = 1'b1;
            ARB_DONE:  w_done[{r_owner_data, ~r_we}] = 1'b1;
            default:   w_mem_req = 1'b0;
        endcase
    end

    // Burst context: latch the winner when leaving IDLE and count beats during BURST.
    always_ff @(posedge clk_l2 or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_data <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_beat       <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_owner_data <= w_pick_data;
                        r_we         <= w_pick_dirty;
                        r_addr       <= ADDR_W'(w_pend[w_pick_idx].addr);
                    end
                end
                ARB_GRANT: r_beat <= '0;
                ARB_BURST: if (mem_beat_ack) r_beat <= r_beat + c_BEAT_W'(1);
                default:   r_beat <= r_beat;
            endcase
        end
    end

    assign w_clr                 = w_done;
    assign mem_req               = w_mem_req;
    assign mem_we                = r_we;
    assign mem_addr              = r_addr;
    assign owner_data            = r_owner_data;
    assign beat_idx              = r_beat;
    assign inst_mem_dirty_done   = w_done[0];
    assign inst_mem_replace_done = w_done[1];
    assign data_mem_dirty_done   = w_done[2];
    assign data_mem_replace_done = w_done[3];

endmodule : l2_mem_arbiter
`default_nettype wire
